// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single register-file write port between the pipeline write-back
// stage (WB) and the multi-cycle multiply/divide unit (MDU).
//
// WB has fixed priority and is never back-pressured. MDU results are accepted
// through a valid/ready handshake into a small FIFO. The FIFO drains one entry
// per cycle whenever WB is not writing. A WB write to register X cancels every
// queued MDU result for X, because WB is younger in program order. A cancelled
// entry keeps its slot and still pops in order, but it pops without writing.
// A starvation timer raises stall_req when the FIFO has been blocked for
// STARVE_LIMIT consecutive cycles. The pipeline then inserts a WB bubble so
// that the head entry can drain.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   wb_we          WB writes this cycle (ignored when wb_rd == 0)
//   wb_rd          WB destination register
//   wb_data        WB write data
//   mdu_valid      MDU result valid
//   mdu_rd         MDU destination register (0 = accepted, then discarded)
//   mdu_data       MDU result
//   mdu_ready      FIFO has a free slot
//   RegWrite       register-file write enable
//   WriteRegister  register-file write address
//   WriteData      register-file write data
//   rs_addr        decode-stage source register 1
//   rt_addr        decode-stage source register 2
//   rs_pending     a live queued result targets rs_addr
//   rt_pending     a live queued result targets rt_addr
//   stall_req      request a one-cycle WB bubble so the FIFO can drain
//   fifo_count     number of live (not cancelled) queued results
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int N            = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_we,
  input  logic [4:0]               wb_rd,
  input  logic [N-1:0]             wb_data,
  input  logic                     mdu_valid,
  input  logic [4:0]               mdu_rd,
  input  logic [N-1:0]             mdu_data,
  output logic                     mdu_ready,
  output logic                     RegWrite,
  output logic [4:0]               WriteRegister,
  output logic [N-1:0]             WriteData,
  input  logic [4:0]               rs_addr,
  input  logic [4:0]               rt_addr,
  output logic                     rs_pending,
  output logic                     rt_pending,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(STARVE_LIMIT) + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_STARVED = 2'd2
  } state_t;

  // FIFO storage. The payload is not reset; r_vld and the occupancy gate it.
  logic [4:0]       r_rd   [DEPTH];
  logic [N-1:0]     r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    r_wptr;
  logic [CW-1:0]    r_occ;   // slots in use, including cancelled entries

  state_t           r_state;
  logic [TW-1:0]    r_timer;
  logic             r_stall;

  logic             w_wb_wr;
  logic             w_nonempty;
  logic             w_pop;
  logic             w_push;
  logic             w_head_vld;
  logic             w_blocked;
  logic [CW-1:0]    w_occ_nxt;
  logic [DEPTH-1:0] w_rs_match;
  logic [DEPTH-1:0] w_rt_match;

  function automatic logic [CW-1:0] count_valid(input logic [DEPTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // A WB write to r0 is not a real write, so the port stays free for the FIFO.
  assign w_wb_wr    = wb_we && (wb_rd != 5'd0);
  assign w_nonempty = (r_occ != '0);
  assign w_pop      = !w_wb_wr && w_nonempty;
  assign w_head_vld = r_vld[r_rptr];
  assign w_blocked  = w_nonempty && !w_pop;

  // mdu_ready depends only on registered occupancy. A slot freed by this
  // cycle's pop therefore cannot be refilled until the next cycle.
  assign mdu_ready  = (r_occ < CW'(DEPTH));
  // A result for r0 completes the handshake but is never stored.
  assign w_push     = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
  assign w_occ_nxt  = r_occ + CW'(w_push) - CW'(w_pop);

  // Write-port mux. A cancelled head still uses the port cycle, but it drives
  // an idle port.
  always_comb begin
    RegWrite      = 1'b0;
    WriteRegister = 5'd0;
    WriteData     = '0;
    if (w_wb_wr) begin
      RegWrite      = 1'b1;
      WriteRegister = wb_rd;
      WriteData     = wb_data;
    end else if (w_pop && w_head_vld) begin
      RegWrite      = 1'b1;
      WriteRegister = r_rd[r_rptr];
      WriteData     = r_data[r_rptr];
    end
  end

  // Hazard flags consider only live entries. This includes the head popping
  // this cycle, because its write is not visible in the register file yet.
  always_comb begin
    w_rs_match = '0;
    w_rt_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_rs_match[i] = r_vld[i] && (r_rd[i] == rs_addr);
      w_rt_match[i] = r_vld[i] && (r_rd[i] == rt_addr);
    end
  end

  assign rs_pending = (rs_addr != 5'd0) && (|w_rs_match);
  assign rt_pending = (rt_addr != 5'd0) && (|w_rt_match);
  assign fifo_count = count_valid(r_vld);
  assign stall_req  = r_stall;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= mdu_rd;
      r_data[r_wptr] <= mdu_data;
    end
  end

  // Valid bits, pointers and occupancy.
  // Per slot, the priority is: an incoming push sets the bit, then the pop
  // clears it, then a WB write to the same rd clears it. The entry being
  // enqueued in the same cycle therefore survives a same-cycle WB kill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld  <= '0;
      r_rptr <= '0;
      r_wptr <= '0;
      r_occ  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (PW'(i) == r_wptr)) begin
          r_vld[i] <= 1'b1;
        end else if (w_pop && (PW'(i) == r_rptr)) begin
          r_vld[i] <= 1'b0;
        end else if (w_wb_wr && (r_rd[i] == wb_rd)) begin
          r_vld[i] <= 1'b0;
        end
      end
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_occ <= w_occ_nxt;
    end
  end

  // Starvation FSM. The timer counts consecutive cycles in which the FIFO
  // holds something but WB owns the port. stall_req is registered and is
  // held until the first pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_stall <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (w_push) begin
            r_state <= S_PENDING;
          end
        end
        S_PENDING: begin
          if (w_pop) begin
            r_timer <= '0;
            if (w_occ_nxt == '0) begin
              r_state <= S_IDLE;
            end
          end else if (w_blocked) begin
            if (r_timer == TW'(STARVE_LIMIT - 1)) begin
              r_state <= S_STARVED;
              r_stall <= 1'b1;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end
        end
        S_STARVED: begin
          if (w_pop) begin
            r_timer <= '0;
            r_stall <= 1'b0;
            r_state <= (w_occ_nxt == '0) ? S_IDLE : S_PENDING;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_timer <= '0;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for regfile_write_arbiter.
//
// The stimulus process drives inputs shortly after each rising edge. It keeps
// a reference model of the pending MDU results as a queue in program order.
// For every cycle it pushes the expected outputs into a scoreboard. A monitor
// compares the DUT against that scoreboard on each falling edge.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  localparam int N            = 32;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic          clk;
  logic          reset;
  logic          wb_we;
  logic [4:0]    wb_rd;
  logic [N-1:0]  wb_data;
  logic          mdu_valid;
  logic [4:0]    mdu_rd;
  logic [N-1:0]  mdu_data;
  logic          mdu_ready;
  logic          RegWrite;
  logic [4:0]    WriteRegister;
  logic [N-1:0]  WriteData;
  logic [4:0]    rs_addr;
  logic [4:0]    rt_addr;
  logic          rs_pending;
  logic          rt_pending;
  logic          stall_req;
  logic [2:0]    fifo_count;

  regfile_write_arbiter #(
    .N(N), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_pending(rs_pending), .rt_pending(rt_pending),
    .stall_req(stall_req), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]   rd;
    logic [N-1:0] data;
    bit           live;
  } ent_t;

  typedef struct {
    logic         we;
    logic [4:0]   rd;
    logic [N-1:0] data;
    bit           chk_port;
    logic         ready;
    int           cnt;
    logic         stall;
    logic         rsp;
    logic         rtp;
  } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  int   starve;
  int   checks;
  int   errors;
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic bit model_pending(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].live && mq[i].rd == a) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive inputs, predict the outputs, advance the model.
  task automatic step(input logic we, input logic [4:0] wrd, input logic [N-1:0] wd,
                      input logic mv, input logic [4:0] mrd, input logic [N-1:0] md,
                      input logic [4:0] rs, input logic [4:0] rt);
    exp_t e;
    ent_t n;
    ent_t gone;
    bit   wbw;
    bit   popped;
    bit   blocked;
    int   c;
    wb_we = we; wb_rd = wrd; wb_data = wd;
    mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
    rs_addr = rs; rt_addr = rt;

    wbw = we && (wrd != 5'd0);
    e.we = 1'b0; e.rd = 5'd0; e.data = '0; e.chk_port = 1'b1;
    e.ready = (mq.size() < DEPTH);
    c = 0;
    foreach (mq[i]) if (mq[i].live) c++;
    e.cnt   = c;
    e.stall = (starve >= STARVE_LIMIT);
    e.rsp   = model_pending(rs);
    e.rtp   = model_pending(rt);
    popped  = 1'b0;
    blocked = 1'b0;
    if (wbw) begin
      e.we = 1'b1; e.rd = wrd; e.data = wd;
      blocked = (mq.size() > 0);
    end else if (mq.size() > 0) begin
      popped = 1'b1;
      if (mq[0].live) begin
        e.we = 1'b1; e.rd = mq[0].rd; e.data = mq[0].data;
      end else begin
        e.chk_port = 1'b0;
      end
    end
    sb.push_back(e);

    if (wbw) foreach (mq[i]) if (mq[i].rd == wrd) mq[i].live = 1'b0;
    if (popped) gone = mq.pop_front();
    if (mv && e.ready && mrd != 5'd0) begin
      n.rd = mrd; n.data = md; n.live = 1'b1;
      mq.push_back(n);
    end
    if (popped) starve = 0;
    else if (blocked) starve++;

    @(posedge clk); #1;
  endtask

  // Assert reset mid-cycle so that only the asynchronous path can clear the
  // outputs before the falling-edge sample.
  task automatic do_reset(input logic [4:0] rs, input logic [4:0] rt);
    exp_t e;
    reset = 1'b0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = '0;
    mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = '0;
    rs_addr = rs; rt_addr = rt;
    mq.delete();
    starve = 0;
    e.we = 1'b0; e.rd = 5'd0; e.data = '0; e.chk_port = 1'b1;
    e.ready = 1'b1; e.cnt = 0; e.stall = 1'b0; e.rsp = 1'b0; e.rtp = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Monitor.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("RegWrite", 32'(RegWrite), 32'(mon_e.we));
      if (mon_e.chk_port) begin
        check("WriteRegister", 32'(WriteRegister), 32'(mon_e.rd));
        check("WriteData", WriteData, mon_e.data);
      end
      check("mdu_ready", 32'(mdu_ready), 32'(mon_e.ready));
      check("fifo_count", 32'(fifo_count), 32'(mon_e.cnt));
      check("stall_req", 32'(stall_req), 32'(mon_e.stall));
      check("rs_pending", 32'(rs_pending), 32'(mon_e.rsp));
      check("rt_pending", 32'(rt_pending), 32'(mon_e.rtp));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; starve = 0;
    reset = 1'b1;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = '0;
    mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = '0;
    rs_addr = 5'd0; rt_addr = 5'd0;
    #1;
    do_reset(5'd0, 5'd0);
    @(posedge clk); #1;

    // Idle after reset.
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd1, 5'd2);
    // WB write goes straight to the port.
    step(1, 5'd8, 32'h55, 0, 5'd0, 32'h0, 5'd8, 5'd0);
    // A WB write to r0 is not a write.
    step(1, 5'd0, 32'hdead, 0, 5'd0, 32'h0, 5'd0, 5'd0);
    // MDU push, then drain on the following cycle.
    step(0, 5'd0, 32'h0, 1, 5'd9, 32'h1234, 5'd9, 5'd0);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd9, 5'd9);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd9, 5'd0);

    // Fill the FIFO under constant WB traffic until stall_req, then drain.
    for (int i = 0; i < 14; i++)
      step(1, 5'd3, 32'h100 + i, 1, 5'(4 + (i % 4)), 32'hA000 + i, 5'd5, 5'd3);
    for (int i = 0; i < 6; i++)
      step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd6, 5'd7);

    // WAW kill: queue rd 12, then WB writes rd 12 while another entry blocks.
    step(0, 5'd0, 32'h0, 1, 5'd12, 32'hC0C0, 5'd12, 5'd12);
    step(1, 5'd12, 32'h77, 1, 5'd13, 32'hD0D0, 5'd13, 5'd12);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd13, 5'd12);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd13, 5'd12);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);

    // A push to r0 is not stored.
    step(0, 5'd0, 32'h0, 1, 5'd0, 32'hBEEF, 5'd0, 5'd0);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Three entries queued behind WB, then reset mid-operation.
    for (int i = 0; i < 3; i++)
      step(1, 5'd2, 32'h9 + i, 1, 5'(20 + i), 32'hE0 + i, 5'd20, 5'd21);
    step(1, 5'd2, 32'h50, 0, 5'd0, 32'h0, 5'd22, 5'd21);
    do_reset(5'd20, 5'd21);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd20, 5'd21);

    // Randomized traffic with bursts of WB writes.
    for (int i = 0; i < 3000; i++) begin
      logic we;
      if ((i % 97) == 50) begin
        do_reset(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end else begin
        we = ((i % 120) < 14) ? 1'b1 : ($urandom_range(0, 99) < 50);
        step(we, 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
    end
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);

    @(negedge clk); #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
